// File: rtl/chirp_sweep_pkg.sv
// chirp_sweep_pkg: FSM states, default widths and count helper for the chirp sweep controller.
// SWEEP_DOWN exists only when CHIRP_SWEEP_TRIANGLE_EN is defined.
package chirp_sweep_pkg;
  localparam int DEF_PHASE_WIDTH  = 64;
  localparam int DEF_CE_DIV_WIDTH = 16;
  localparam int DEF_CNT_WIDTH    = 16;
`ifdef CHIRP_SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {IDLE, SWEEP, SWEEP_DOWN} state_t;
`else
  typedef enum logic [1:0] {IDLE, SWEEP} state_t;
`endif
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/sample_ce_divider.sv
// sample_ce_divider: free-running clock divider producing the registered sample strobe.
module sample_ce_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [W-1:0] ce_divisor,
  output logic         sample_clk_ce
);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] r_cnt, r_div;
  logic         r_ce, w_wrap;
  // divisor is sampled only at a wrap so a mid-period change cannot strand the counter
  assign w_wrap = (r_div <= ONE) || (r_cnt == r_div - ONE);
  assign sample_clk_ce = r_ce;
  always_ff @(posedge clk) begin
    if (arst) begin
      r_cnt <= '0;
      r_div <= ce_divisor;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= w_wrap;
      r_cnt <= w_wrap ? '0 : r_cnt + ONE;
      r_div <= w_wrap ? ce_divisor : r_div;
    end
  end
endmodule

// File: rtl/chirp_sweep_controller.sv
// chirp_sweep_controller: sample strobe and linear phase-increment sweep for the LUT sine generator.
// Define CHIRP_SWEEP_TRIANGLE_EN to add triangle_mode (up then down sweeps).
module chirp_sweep_controller
  import chirp_sweep_pkg::*;
#(
  parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int CE_DIV_WIDTH = DEF_CE_DIV_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [CE_DIV_WIDTH-1:0]       ce_divisor,
  input  logic                          start,
  input  logic                          abort,
  input  logic signed [PHASE_WIDTH-1:0] start_increment,
  input  logic signed [PHASE_WIDTH-1:0] step_increment,
  input  logic [CNT_WIDTH-1:0]          num_steps,
  input  logic [CNT_WIDTH-1:0]          dwell_samples,
  input  logic                          repeat_en,
`ifdef CHIRP_SWEEP_TRIANGLE_EN
  input  logic                          triangle_mode,
`endif
  output logic                          sample_clk_ce,
  output logic signed [PHASE_WIDTH-1:0] phase_increment,
  output logic [CNT_WIDTH-1:0]          step_index,
  output logic                          busy,
  output logic                          done
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t                        r_state, w_state_nx;
  logic signed [PHASE_WIDTH-1:0] r_phase, w_phase_nx, r_start_inc, r_step_inc;
  logic [CNT_WIDTH-1:0]          r_idx, w_idx_nx, r_dwell, w_dwell_nx, r_steps, r_dwells;
  logic                          r_rep, r_done, w_done_nx, w_ce, w_go, w_last_dwell, w_more_up;
`ifdef CHIRP_SWEEP_TRIANGLE_EN
  logic                          r_tri;
`endif

  sample_ce_divider #(.W(CE_DIV_WIDTH)) u_div (
    .clk(clk),
    .arst(arst),
    .ce_divisor(ce_divisor),
    .sample_clk_ce(w_ce)
  );

  assign sample_clk_ce   = w_ce;
  assign phase_increment = r_phase;
  assign step_index      = r_idx;
  assign busy            = r_state != IDLE;
  assign done            = r_done;
  assign w_go            = (r_state == IDLE) && start && !abort;
  assign w_last_dwell    = r_dwell == r_dwells - ONE;
  assign w_more_up       = r_idx < r_steps - ONE;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_idx_nx   = r_idx;
    w_dwell_nx = r_dwell;
    w_done_nx  = 1'b0;
    if (abort) begin
      w_state_nx = IDLE;
      w_phase_nx = '0;
      w_idx_nx   = '0;
      w_dwell_nx = '0;
    end else if (w_go) begin
      w_state_nx = SWEEP;
      w_phase_nx = start_increment;
      w_idx_nx   = '0;
      w_dwell_nx = '0;
    end else if (r_state != IDLE && w_ce) begin
      w_dwell_nx = w_last_dwell ? '0 : r_dwell + ONE;
      if (w_last_dwell) begin
        if (r_state == SWEEP && w_more_up) begin
          w_phase_nx = r_phase + r_step_inc;
          w_idx_nx   = r_idx + ONE;
        end
`ifdef CHIRP_SWEEP_TRIANGLE_EN
        else if (r_state == SWEEP && r_tri && r_steps > ONE) begin
          w_state_nx = SWEEP_DOWN;
          w_phase_nx = r_phase - r_step_inc;
          w_idx_nx   = r_idx - ONE;
        end else if (r_state == SWEEP_DOWN && r_idx != '0) begin
          w_phase_nx = r_phase - r_step_inc;
          w_idx_nx   = r_idx - ONE;
        end
`endif
        else if (r_rep) begin
          w_state_nx = SWEEP;
          w_phase_nx = r_start_inc;
          w_idx_nx   = '0;
        end else begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_done      <= 1'b0;
      r_start_inc <= '0;
      r_step_inc  <= '0;
      r_steps     <= ONE;
      r_dwells    <= ONE;
      r_rep       <= 1'b0;
`ifdef CHIRP_SWEEP_TRIANGLE_EN
      r_tri       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_idx   <= w_idx_nx;
      r_dwell <= w_dwell_nx;
      r_done  <= w_done_nx;
      if (w_go) begin
        r_start_inc <= start_increment;
        r_step_inc  <= step_increment;
        r_steps     <= CNT_WIDTH'(at_least_one(32'(num_steps)));
        r_dwells    <= CNT_WIDTH'(at_least_one(32'(dwell_samples)));
        r_rep       <= repeat_en;
`ifdef CHIRP_SWEEP_TRIANGLE_EN
        r_tri       <= triangle_mode;
`endif
      end
    end
  end
endmodule
